// File: rtl/alu_result_stage.sv
// alu_result_stage: registered 2-entry output buffer behind the 8-bit
// adder/subtracter. It captures SUM, the status flags and the op bit under a
// valid/ready handshake and derives Borrow for subtraction. A saturating
// counter tracks how many accepted results had Overflow set.
// Optional feature macro: ALU_STICKY_FLAGS_EN adds sticky_clr/sticky_flags,
// which OR-accumulate {N,Z,V,C} over every pushed result.
module alu_result_stage #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     SUM,
  input  logic                 Carry_out,
  input  logic                 zero,
  input  logic                 Overflow,
  input  logic                 Negative,
  input  logic                 control_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [4:0]           out_flags,
  output logic                 out_sub,
`ifdef ALU_STICKY_FLAGS_EN
  input  logic                 sticky_clr,
  output logic [3:0]           sticky_flags,
`endif
  output logic [CNT_WIDTH-1:0] ovf_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [4:0]       flags;  // {Borrow, Negative, zero, Overflow, Carry_out}
    logic             sub;
  } entry_t;

  entry_t       mem [2];
  logic         rptr, wptr;
  logic [1:0]   count, count_nxt;
  logic         rdy_q;
  logic         push, pop;
  entry_t       wr_entry;

  assign push      = in_valid & rdy_q;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign in_ready  = rdy_q;

  // Head entry drives the outputs; it only changes on a pop or a push into empty.
  assign out_result = mem[rptr].result;
  assign out_flags  = mem[rptr].flags;
  assign out_sub    = mem[rptr].sub;

  // Build the entry to capture; Borrow is the inverted carry of a subtract.
  always_comb begin
    wr_entry        = '0;
    wr_entry.result = SUM;
    wr_entry.flags  = {control_in & ~Carry_out, Negative, zero, Overflow, Carry_out};
    wr_entry.sub    = control_in;
  end

  // Next occupancy; push and pop together leave the count unchanged.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // FIFO state. in_ready is registered from the next occupancy so it never
  // depends combinationally on out_ready or in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rptr   <= 1'b0;
      wptr   <= 1'b0;
      count  <= 2'd0;
      rdy_q  <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= wr_entry;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count_nxt;
      rdy_q <= (count_nxt < 2'd2);
    end
  end

  // Overflow-event counter; counts at capture time and sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst)
      ovf_count <= '0;
    else if (push && Overflow && (ovf_count != {CNT_WIDTH{1'b1}}))
      ovf_count <= ovf_count + 1'b1;
  end

`ifdef ALU_STICKY_FLAGS_EN
  // Sticky flags: a clear in the same cycle as a push keeps that push's flags.
  always_ff @(posedge clk) begin
    if (rst)
      sticky_flags <= 4'b0;
    else
      sticky_flags <= (sticky_clr ? 4'b0 : sticky_flags) |
                      (push ? {Negative, zero, Overflow, Carry_out} : 4'b0);
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage. Inputs are driven and outputs are
// sampled on the falling edge, so each check observes state after the
// preceding rising edge.
module tb_alu_result_stage;

  localparam int WIDTH = 8;
  localparam int CNT_WIDTH = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     SUM;
  logic                 Carry_out, zero, Overflow, Negative, control_in;
  logic                 out_valid, out_ready;
  logic [WIDTH-1:0]     out_result;
  logic [4:0]           out_flags;
  logic                 out_sub;
  logic [CNT_WIDTH-1:0] ovf_count;
`ifdef ALU_STICKY_FLAGS_EN
  logic                 sticky_clr;
  logic [3:0]           sticky_flags;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .SUM(SUM), .Carry_out(Carry_out), .zero(zero), .Overflow(Overflow),
    .Negative(Negative), .control_in(control_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_sub(out_sub),
`ifdef ALU_STICKY_FLAGS_EN
    .sticky_clr(sticky_clr), .sticky_flags(sticky_flags),
`endif
    .ovf_count(ovf_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one adder result: {sum, C, Z, V, N, sub}.
  task automatic drive(input logic [7:0] s, input logic c, input logic z,
                       input logic v, input logic n, input logic sub);
    in_valid = 1'b1; SUM = s; Carry_out = c; zero = z;
    Overflow = v; Negative = n; control_in = sub;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; SUM = '0;
    Carry_out = 0; zero = 0; Overflow = 0; Negative = 0; control_in = 0;
`ifdef ALU_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif
    step(); step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_out_sub", out_sub, 0);
    check("rst_ovf_count", ovf_count, 0);

    rst = 1'b0;
    step();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // Simple add 5: appears next cycle, drains the cycle after.
    out_ready = 1'b1;
    drive(8'h05, 0, 0, 0, 0, 0);
    step();
    in_valid = 1'b0;
    check("add5_valid", out_valid, 1);
    check("add5_result", out_result, 8'h05);
    check("add5_flags", out_flags, 5'b00000);
    step();
    check("add5_drained", out_valid, 0);

    // 7F+01 overflow: N=1, V=1.
    drive(8'h80, 0, 0, 1, 1, 0);
    step();
    in_valid = 1'b0;
    check("ovf_result", out_result, 8'h80);
    check("ovf_flags", out_flags, 5'b01010);
    check("ovf_count1", ovf_count, 1);
    step();

    // 3-5 subtract: no carry -> Borrow.
    drive(8'hFE, 0, 0, 0, 1, 1);
    step();
    in_valid = 1'b0;
    check("sub_valid", out_valid, 1);
    check("sub_result", out_result, 8'hFE);
    check("sub_flags", out_flags, 5'b11000);
    check("sub_out_sub", out_sub, 1);
    check("sub_ovf_hold", ovf_count, 1);
    step();

    // Backpressure: A, B, C back-to-back with out_ready low.
    out_ready = 1'b0;
    drive(8'h11, 1, 0, 0, 0, 0);
    step();
    check("bp_one_in_ready", in_ready, 1);
    drive(8'h22, 0, 0, 0, 0, 0);
    step();
    check("bp_full_in_ready", in_ready, 0);
    check("bp_head_A", out_result, 8'h11);
    check("bp_head_A_flags", out_flags, 5'b00001);
    drive(8'h33, 0, 0, 0, 0, 0);
    step();
    check("bp_C_rejected_in_ready", in_ready, 0);
    check("bp_head_A_stable", out_result, 8'h11);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_pop_head_B", out_result, 8'h22);
    check("bp_pop_in_ready", in_ready, 1);
    check("bp_pop_valid", out_valid, 1);
    step();
    check("bp_C_never_stored", out_valid, 0);

    // count=1 with simultaneous push and pop.
    out_ready = 1'b0;
    drive(8'h44, 0, 0, 0, 0, 0);
    step();
    check("sim_head_D", out_result, 8'h44);
    drive(8'h55, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("sim_valid", out_valid, 1);
    check("sim_head_E", out_result, 8'h55);
    check("sim_in_ready", in_ready, 1);
    drive(8'h66, 0, 0, 1, 0, 0);
    step();
    check("sim_full", in_ready, 0);
    check("sim_ovf2", ovf_count, 2);

    // Reset with two entries held and a pending push.
    rst = 1'b1;
    drive(8'h77, 0, 0, 1, 0, 0);
    step();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ovf", ovf_count, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    check("mid_rst_discard", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);

    // Saturation: 300 overflow pushes, draining every cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive(8'h80, 0, 0, 1, 1, 0);
      step();
      if (i == 9)   check("sat_count10", ovf_count, 10);
      if (i == 254) check("sat_count255", ovf_count, 8'hFF);
    end
    in_valid = 1'b0;
    check("sat_final", ovf_count, 8'hFF);
    check("sat_in_ready", in_ready, 1);

`ifdef ALU_STICKY_FLAGS_EN
    check("sticky_after_sat", sticky_flags, 4'b1010);
    step();
    check("sticky_hold", sticky_flags, 4'b1010);
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    check("sticky_cleared", sticky_flags, 4'b0000);
    sticky_clr = 1'b1;
    drive(8'h00, 1, 1, 0, 0, 0);
    step();
    sticky_clr = 1'b0;
    in_valid = 1'b0;
    check("sticky_clr_with_push", sticky_flags, 4'b0101);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
